// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer that drains one register-file write per cycle.
// Optional feature macro WB_ZERO_DISCARD_EN: drop writes to register 0 and mask queries for it.
module wb_write_queue #(
   parameter int N = 32,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Wb_Valid_i,
   output logic          Wb_Ready_o,
   input  logic [4:0]    Wb_Register_i,
   input  logic [N-1:0]  Wb_Data_i,
   input  logic          Stall_i,
   output logic          Reg_Write_o,
   output logic [4:0]    Write_Register_o,
   output logic [N-1:0]  Write_Data_o,
   input  logic [4:0]    Query_Register_i,
   output logic          Query_Hit_o,
   output logic [CW-1:0] Count_o,
   output logic          Full_o,
   output logic          Empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [4:0]    reg_mem  [DEPTH];
   logic [N-1:0]  data_mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, enq;
   logic [DEPTH-1:0] slot_valid;

   assign Count_o    = count_q;
   assign Full_o     = (count_q == CW'(DEPTH));
   assign Empty_o    = (count_q == '0);
   assign Wb_Ready_o = reset & ~Full_o;
   assign push       = Wb_Valid_i & Wb_Ready_o;
   assign pop        = ~Empty_o & ~Stall_i;

`ifdef WB_ZERO_DISCARD_EN
   // Handshake still completes; the request just never occupies a slot.
   assign enq = push & (Wb_Register_i != 5'd0);
`else
   assign enq = push;
`endif

   always_comb begin
      count_d = count_q;
      unique case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         reg_mem[wr_ptr_q]  <= Wb_Register_i;
         data_mem[wr_ptr_q] <= Wb_Data_i;
      end
   end

   // Output stage: address/data hold their last value when nothing drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Reg_Write_o      <= 1'b0;
         Write_Register_o <= '0;
         Write_Data_o     <= '0;
      end else begin
         Reg_Write_o <= pop;
         if (pop) begin
            Write_Register_o <= reg_mem[rd_ptr_q];
            Write_Data_o     <= data_mem[rd_ptr_q];
         end
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [PW-1:0] offs;
      offs       = '0;
      slot_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs          = PW'(i) - rd_ptr_q;
         slot_valid[i] = ({1'b0, offs} < count_q);
      end
   end

   always_comb begin
      Query_Hit_o = Reg_Write_o && (Write_Register_o == Query_Register_i);
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_valid[i] && (reg_mem[i] == Query_Register_i)) Query_Hit_o = 1'b1;
      end
`ifdef WB_ZERO_DISCARD_EN
      if (Query_Register_i == 5'd0) Query_Hit_o = 1'b0;
`endif
   end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: constant vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_wb_write_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          Wb_Valid_i, Wb_Ready_o, Stall_i;
   logic [4:0]    Wb_Register_i, Write_Register_o, Query_Register_i;
   logic [N-1:0]  Wb_Data_i, Write_Data_o;
   logic          Reg_Write_o, Query_Hit_o, Full_o, Empty_o;
   logic [CW-1:0] Count_o;

   wb_write_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .Wb_Valid_i(Wb_Valid_i), .Wb_Ready_o(Wb_Ready_o),
      .Wb_Register_i(Wb_Register_i), .Wb_Data_i(Wb_Data_i),
      .Stall_i(Stall_i),
      .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
      .Write_Data_o(Write_Data_o),
      .Query_Register_i(Query_Register_i), .Query_Hit_o(Query_Hit_o),
      .Count_o(Count_o), .Full_o(Full_o), .Empty_o(Empty_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]   r;
      logic [N-1:0] d;
   } entry_t;

   // Reference model: FIFO of pending writes plus the register-file output stage.
   entry_t       q[$];
   logic         m_rw;
   logic [4:0]   m_wreg;
   logic [N-1:0] m_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic m_hit(input logic [4:0] qr);
      logic h;
      h = m_rw && (m_wreg == qr);
      foreach (q[i]) if (q[i].r == qr) h = 1'b1;
`ifdef WB_ZERO_DISCARD_EN
      if (qr == 5'd0) h = 1'b0;
`endif
      return h;
   endfunction

   function automatic void m_reset();
      q.delete();
      m_rw    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
   endfunction

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step(input string tag);
      bit     do_push, do_pop;
      entry_t e, h;
      #1;
      check({tag, ".ready"}, Wb_Ready_o, q.size() < DEPTH);
      check({tag, ".hit"}, Query_Hit_o, m_hit(Query_Register_i));
      do_push = Wb_Valid_i && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && !Stall_i;
      e.r = Wb_Register_i;
      e.d = Wb_Data_i;
      @(posedge clk);
      if (do_pop) begin
         h       = q.pop_front();
         m_rw    = 1'b1;
         m_wreg  = h.r;
         m_wdata = h.d;
      end else begin
         m_rw = 1'b0;
      end
`ifdef WB_ZERO_DISCARD_EN
      if (do_push && e.r != 5'd0) q.push_back(e);
`else
      if (do_push) q.push_back(e);
`endif
      @(negedge clk);
      check({tag, ".rw"}, Reg_Write_o, m_rw);
      check({tag, ".wreg"}, Write_Register_o, m_wreg);
      check({tag, ".wdata"}, Write_Data_o, m_wdata);
      check({tag, ".count"}, Count_o, q.size());
      check({tag, ".full"}, Full_o, q.size() == DEPTH);
      check({tag, ".empty"}, Empty_o, q.size() == 0);
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic [N-1:0] d,
                        input logic st, input logic [4:0] qr);
      Wb_Valid_i       = v;
      Wb_Register_i    = r;
      Wb_Data_i        = d;
      Stall_i          = st;
      Query_Register_i = qr;
   endtask

   task automatic drain();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
      for (int i = 0; i < DEPTH + 2; i++) step("drain");
   endtask

   typedef struct {
      logic         v;
      logic [4:0]   r;
      logic [31:0]  d;
      logic         st;
      logic [4:0]   qr;
      logic         e_hit;
      logic         e_rw;
      logic [4:0]   e_wreg;
      logic [31:0]  e_wdata;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0,        CW'(1)};
      tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, CW'(0)};
      tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, CW'(0)};
      tbl[3] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd5, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, CW'(1)};
      tbl[4] = '{1'b1, 5'd8, 32'h22,       1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, CW'(2)};
      tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 1'b1, 1'b1, 5'd7, 32'h11,       CW'(1)};
      tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 1'b1, 5'd8, 32'h22,       CW'(0)};
      tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b0, 1'b0, 5'd8, 32'h22,       CW'(0)};

      // Power-up reset
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
      reset = 1'b0;
      m_reset();
      #1;
      check("por.ready", Wb_Ready_o, 1'b0);
      check("por.rw", Reg_Write_o, 1'b0);
      check("por.empty", Empty_o, 1'b1);
      check("por.full", Full_o, 1'b0);
      check("por.count", Count_o, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Vector table: single write latency, hold behaviour, query through output stage
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].st, tbl[i].qr);
         #1;
         check($sformatf("tbl%0d.hit", i), Query_Hit_o, tbl[i].e_hit);
         step($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d.rw_c", i), Reg_Write_o, tbl[i].e_rw);
         check($sformatf("tbl%0d.wreg_c", i), Write_Register_o, tbl[i].e_wreg);
         check($sformatf("tbl%0d.wdata_c", i), Write_Data_o, tbl[i].e_wdata);
         check($sformatf("tbl%0d.cnt_c", i), Count_o, tbl[i].e_cnt);
      end
      drain();

      // Fill while stalled, 5th request held, then in-order drain
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 32'(100 + i), 1'b1, 5'd9);
         step("fill");
      end
      drive(1'b1, 5'd5, 32'd105, 1'b1, 5'd3);
      #1;
      check("full.flag", Full_o, 1'b1);
      check("full.ready", Wb_Ready_o, 1'b0);
      step("held");
      check("held.count", Count_o, 4);
      drive(1'b1, 5'd5, 32'd105, 1'b0, 5'd3);
      step("rel1");
      check("rel1.wreg", Write_Register_o, 5'd1);
      step("rel2");
      check("rel2.wreg", Write_Register_o, 5'd2);
      drive(1'b0, 5'd0, '0, 1'b0, 5'd3);
      for (int i = 3; i <= 5; i++) begin
         step("rel");
         check($sformatf("rel%0d.rw", i), Reg_Write_o, 1'b1);
         check($sformatf("rel%0d.wreg", i), Write_Register_o, 5'(i));
         check($sformatf("rel%0d.wdata", i), Write_Data_o, 32'(100 + i));
      end
      drain();

      // Register 0 handling
      drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
      #1;
      check("zero.ready", Wb_Ready_o, 1'b1);
      step("zero0");
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
`ifdef WB_ZERO_DISCARD_EN
      check("zero.count", Count_o, 0);
      step("zero1");
      check("zero.rw", Reg_Write_o, 1'b0);
`else
      check("zero.count", Count_o, 1);
      #1;
      check("zero.hit", Query_Hit_o, 1'b1);
      step("zero1");
      check("zero.rw", Reg_Write_o, 1'b1);
      check("zero.wreg", Write_Register_o, 5'd0);
      check("zero.wdata", Write_Data_o, 32'h1234);
`endif
      drain();

      // Sustained push+pop across pointer wrap
      drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd0);
      step("cont.pre");
      drive(1'b1, 5'd11, 32'hA1, 1'b1, 5'd0);
      step("cont.pre");
      for (int i = 0; i < 2 * DEPTH + 3; i++) begin
         drive(1'b1, 5'(12 + i), $urandom, 1'b0, 5'(12 + i));
         step("cont");
         check("cont.count", Count_o, 2);
      end
      drain();

      // Asynchronous reset mid-drain with three entries queued
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(20 + i), 32'(200 + i), 1'b1, 5'd0);
         step("prerst");
      end
      drive(1'b0, 5'd0, '0, 1'b0, 5'd22);
      step("prerst.pop");
      check("prerst.count", Count_o, 3);
      #2;
      reset = 1'b0;
      #1;
      check("rst.rw", Reg_Write_o, 1'b0);
      check("rst.wreg", Write_Register_o, 5'd0);
      check("rst.wdata", Write_Data_o, 32'd0);
      check("rst.hit", Query_Hit_o, 1'b0);
      check("rst.count", Count_o, 0);
      check("rst.empty", Empty_o, 1'b1);
      check("rst.full", Full_o, 1'b0);
      check("rst.ready", Wb_Ready_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("rst.hold_ready", Wb_Ready_o, 1'b0);
      reset = 1'b1;
      m_reset();
      for (int i = 0; i < 3; i++) step("postrst");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 8)));
         step("rand");
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback queue sitting in front of the register file write port. Accepts register-write requests from the execute/memory stages over a valid/ready handshake, buffers up to DEPTH of them in order, and drains one per cycle into the register file's Reg_Write/Write_Register/Write_Data inputs. Also answers a combinational hazard query: whether a write to a given register is still pending.

## Interface
- N, 32, data width; must match the register file width
- DEPTH, 4, queue entries; power of two, 2..16
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Wb_Valid_i  in  1  request valid
- Wb_Ready_o  out  1  queue can accept; 0 while reset is low
- Wb_Register_i  in  5  destination register
- Wb_Data_i  in  N  data to write
- Stall_i  in  1  1 = hold the drain (no pop this cycle)
- Reg_Write_o  out  1  write strobe to the register file
- Write_Register_o  out  5  register file write address
- Write_Data_o  out  N  register file write data
- Query_Register_i  in  5  register checked for a pending write
- Query_Hit_o  out  1  pending write to Query_Register_i exists
- Count_o  out  CW  queued entries (excluding output stage)
- Full_o / Empty_o  out  1 each  Count_o == DEPTH / Count_o == 0

## Operation
- Storage: DEPTH x (5+N) circular buffer, write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
- Push: Wb_Valid_i & Wb_Ready_o at a rising edge writes {Wb_Register_i, Wb_Data_i} at the write pointer and advances it. Wb_Ready_o = !Full_o (combinational, no full-bypass).
- Pop: at each edge with !Empty_o & !Stall_i, head entry loads the output stage (Reg_Write_o<=1, Write_Register_o, Write_Data_o) and the read pointer advances.
- No pop at an edge (empty or stalled): Reg_Write_o<=0; Write_Register_o/Write_Data_o hold their last values.
- Simultaneous push and pop: both occur, Count_o unchanged; entry order preserved, including when the two pointers are equal.
- Query_Hit_o = OR over valid queue entries and the output stage (when Reg_Write_o=1) of (register == Query_Register_i). Combinational.
- Reset (async, any time, including mid-drain): pointers and count to 0, Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, Query_Hit_o=0, Empty_o=1, Full_o=0, Wb_Ready_o=0 until reset returns high. Queued entries are discarded.

## Timing
- Push accepted at edge E0 -> earliest Reg_Write_o high in the cycle after E1 -> register file captures at E2 (2-cycle push-to-write latency).
- Throughput: one push and one pop per cycle sustained.
- Count_o, Full_o, Empty_o update at the edge of the push/pop; Wb_Ready_o follows in the same cycle.
- Stall_i sampled at the edge; stall of k cycles delays every queued write by k cycles, nothing dropped.

## Configuration
- WB_ZERO_DISCARD_EN defined: requests with Wb_Register_i==0 complete the handshake but are not enqueued (Count_o unchanged, no Reg_Write_o); Query_Hit_o is forced 0 when Query_Register_i==0.
- Not defined: register 0 is queued and written like any other; queries for 0 may hit.

## Test plan
- Reset low mid-operation with 3 entries queued -> all outputs at reset values immediately; after release Count_o=0, Wb_Ready_o=1, no Reg_Write_o pulses.
- Push {5, 0xDEADBEEF} at E0, Stall_i=0 -> Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF in the cycle after E1 only.
- Push 4 entries (regs 1..4) with Stall_i=1 -> Full_o=1, Wb_Ready_o=0, 5th request held; release stall -> writes 1,2,3,4 on consecutive cycles, then 5th accepted.
- Continuous push+pop for 2*DEPTH+3 cycles -> Count_o constant, data in order across pointer wrap.
- Queue holds reg 7 -> Query_Register_i=7 gives Query_Hit_o=1 until the cycle its Reg_Write_o pulse ends, then 0; Query_Register_i=8 gives 0.
- Push reg 0 data 0x1234: with WB_ZERO_DISCARD_EN -> handshake done, Count_o stays 0, no write; without -> Reg_Write_o=1, Write_Register_o=0.
